// File: rtl/disp_seq_ctrl.sv
// disp_seq_ctrl: steps through 16-bit ROM frames on a 1 ms tick and scans them
// onto a 4-digit common-anode 7-segment display.
module disp_seq_ctrl #(
    parameter int FRAME_MS   = 500,
    parameter int NUM_FRAMES = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ms_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] frame_addr,
    input  logic [15:0]       frame_data,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] SHOW  = 2'd3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_FRAMES - 1);
    localparam logic [15:0]       LAST_MS   = 16'(FRAME_MS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       disp_q, disp_d;
    logic [15:0]       ms_cnt_q, ms_cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              done_q, done_d;
    logic              frame_end;
    logic [3:0]        nib;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'b1000000;
            4'h1: hex7seg = 7'b1111001;
            4'h2: hex7seg = 7'b0100100;
            4'h3: hex7seg = 7'b0110000;
            4'h4: hex7seg = 7'b0011001;
            4'h5: hex7seg = 7'b0010010;
            4'h6: hex7seg = 7'b0000010;
            4'h7: hex7seg = 7'b1111000;
            4'h8: hex7seg = 7'b0000000;
            4'h9: hex7seg = 7'b0010000;
            4'hA: hex7seg = 7'b0001000;
            4'hB: hex7seg = 7'b0000011;
            4'hC: hex7seg = 7'b1000110;
            4'hD: hex7seg = 7'b0100001;
            4'hE: hex7seg = 7'b0000110;
            default: hex7seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        disp_d    = disp_q;
        ms_cnt_d  = ms_cnt_q;
        done_d    = 1'b0;
        frame_end = (state_q == SHOW) && ms_tick && (ms_cnt_q == LAST_MS);
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: if (start && !stop) begin
                    state_d = FETCH;
                    addr_d  = '0;
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    disp_d   = frame_data;
                    ms_cnt_d = '0;
                    state_d  = SHOW;
                end
                default: if (frame_end) begin
                    addr_d  = (addr_q != LAST_ADDR) ? addr_q + 1'b1 : '0;
                    state_d = (addr_q != LAST_ADDR || loop) ? FETCH : IDLE;
                    done_d  = (addr_q == LAST_ADDR) && !loop;
                end else if (ms_tick) begin
                    ms_cnt_d = ms_cnt_q + 16'd1;
                end
            endcase
        end
        // the scan keeps running across frame fetches so the display never stalls
        digit_d = digit_q + 2'((state_q != IDLE) && ms_tick);
        nib     = disp_q[{digit_q, 2'b00} +: 4];
        an_d    = (state_d == IDLE) ? 4'hF : ~(4'b0001 << digit_q);
        seg_d   = (state_d == IDLE) ? 7'h7F : hex7seg(nib);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            disp_q   <= '0;
            ms_cnt_q <= '0;
            digit_q  <= '0;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            disp_q   <= disp_d;
            ms_cnt_q <= ms_cnt_d;
            digit_q  <= digit_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            done_q   <= done_d;
        end
    end

    assign frame_addr = addr_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
endmodule

// File: tb/tb_disp_seq_ctrl.sv
// tb_disp_seq_ctrl: randomized scoreboard bench for disp_seq_ctrl against a
// frame/tick-level reference model.
module tb_disp_seq_ctrl;
    localparam int FMS = 3;
    localparam int NF  = 4;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst, ms_tick, start, stop, loop;
    logic [AW-1:0] frame_addr;
    logic [15:0]   frame_data;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp, busy, done;

    disp_seq_ctrl #(.FRAME_MS(FMS), .NUM_FRAMES(NF), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ms_tick(ms_tick), .start(start), .stop(stop),
        .loop(loop), .frame_addr(frame_addr), .frame_data(frame_data),
        .an(an), .seg(seg), .dp(dp), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [8];
    always_ff @(posedge clk) frame_data <= rom[frame_addr];

    typedef struct packed {
        logic [AW-1:0] fa;
        logic [3:0]    an;
        logic [6:0]    seg;
        logic          dp;
        logic          busy;
        logic          done;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   lp_q = 1'b0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model: sequence position in frames, ticks and fetch latency
    bit          m_act;
    int          m_since, m_frame, m_ticks, m_scan;
    logic [15:0] m_shown;

    task automatic model_reset();
        m_act = 0; m_since = 0; m_frame = 0; m_ticks = 0; m_scan = 0; m_shown = '0;
    endtask

    task automatic step(input bit s, input bit p, input bit t);
        obs_t        e;
        int          sc;
        logic [15:0] sh;
        bit          was;
        e = '0;
        if (!rst) model_reset();
        else begin
            sc = m_scan; sh = m_shown; was = m_act;
            if (!was) begin
                if (s && !p) begin m_act = 1; m_since = 0; m_frame = 0; end
            end else if (p) begin
                m_act = 0; m_frame = 0;
            end else if (m_since < 2) begin
                m_since++;
                if (m_since == 2) begin m_shown = rom[m_frame]; m_ticks = 0; end
            end else if (t) begin
                m_ticks++;
                if (m_ticks == FMS) begin
                    if (m_frame < NF - 1) begin m_frame++; m_since = 0; end
                    else begin
                        m_frame = 0;
                        if (loop) m_since = 0;
                        else begin m_act = 0; e.done = 1; end
                    end
                end
            end
            if (was && t) m_scan = (m_scan + 1) % 4;
            e.an  = m_act ? ~(4'b0001 << sc) : 4'hF;
            e.seg = m_act ? hex_tab[sh[4*sc +: 4]] : 7'h7F;
        end
        if (!rst) begin e.an = 4'hF; e.seg = 7'h7F; end
        e.fa   = AW'(m_frame);
        e.dp   = 1'b1;
        e.busy = m_act;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input bit t);
        @(posedge clk);
        #2;
        rst = r; start = s; stop = p; ms_tick = t; loop = lp_q;
        step(s, p, t);
    endtask

    initial begin
        obs_t e, o;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = {frame_addr, an, seg, dp, busy, done};
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL obs t=%0t: got fa=%0d an=%b seg=%b dp=%b busy=%b done=%b, exp fa=%0d an=%b seg=%b dp=%b busy=%b done=%b",
                             $time, o.fa, o.an, o.seg, o.dp, o.busy, o.done,
                             e.fa, e.an, e.seg, e.dp, e.busy, e.done);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    initial begin
        rst = 1'b0; start = 0; stop = 0; ms_tick = 0; loop = 0;
        for (int i = 0; i < 8; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h1230;
        model_reset();
        repeat (3) cyc(0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0);
        // single pass, tick every 10 cycles
        lp_q = 0;
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 140; i++) cyc(1, 0, 0, (i % 10) == 9);
        // looping pass with start pulses while busy, then stop mid-frame 2
        for (int i = 1; i < 8; i++) rom[i] = 16'($urandom);
        lp_q = 1;
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 160; i++) cyc(1, ($urandom % 7) == 0, 0, (i % 10) == 9);
        begin
            int i;
            for (i = 0; i < 200 && !(m_frame == 2 && m_since >= 2 && m_ticks == 1); i++)
                cyc(1, 0, 0, (i % 10) == 9);
            check("reach_frame2", 16'(i < 200), 16'd1);
        end
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (5) cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 60; i++) cyc(1, 0, 0, (i % 10) == 9);
        // ticks every cycle: ticks land in FETCH/LOAD and on frame ends
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 1);
        lp_q = 0;
        for (int i = 0; i < 40; i++) cyc(1, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 200) == 0) lp_q = ~lp_q;
            cyc(1, ($urandom % 40) == 0, ($urandom % 150) == 0, ($urandom % 3) == 0);
        end
        // asynchronous reset in the middle of SHOW
        lp_q = 1;
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, (i % 3) == 2);
        check("busy_before_areset", 16'(busy), 16'd1);
        @(posedge clk);
        #2;
        start = 0; stop = 0; ms_tick = 0;
        rst = 1'b0;
        #1;
        check("areset_an", 16'(an), 16'h000F);
        check("areset_seg", 16'(seg), 16'h007F);
        check("areset_busy", 16'(busy), 16'd0);
        check("areset_addr", 16'(frame_addr), 16'd0);
        step(0, 0, 0);
        cyc(0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 50; i++) cyc(1, 0, 0, (i % 5) == 4);
        cyc(1, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
